fpu_arb: RTL and testbench

//  Round-robin scheduler sharing one FPU core (val/cmd/din1/din2 -> done/result) between NREQ requesters.

---
 rtl/fpu_arb_pkg.sv | 17 +
 rtl/fpu_arb_if.sv | 29 ++
 rtl/fpu_arb_rr_arbiter.sv | 35 +++
 rtl/fpu_arb.sv | 164 ++++++++++++++++
 tb/tb_fpu_arb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and widths for the FPU arbiter slice.
// Contents:
//   fpu_arb_st_e  scheduler state (IDLE, ISSUE, WAIT)
//   FPU_CMD_W     width of an FPU command
//   FPU_DATA_W    width of an FPU operand/result
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fpu_arb_st_e;

  localparam int FPU_CMD_W  = 4;
  localparam int FPU_DATA_W = 32;

endpackage

// File: rtl/fpu_arb_if.sv
// Bus between the arbiter and the shared FPU datapath.
// Signals:
//   fpu_val     one-cycle start strobe towards the FPU
//   fpu_cmd     command for the operation
//   fpu_din1/2  operands for the operation
//   fpu_done    completion pulse from the FPU
//   fpu_result  result, valid with fpu_done
// Modports: master = arbiter side, slave = FPU side.
interface fpu_arb_if;
  import fpu_arb_pkg::*;

  logic                  fpu_val;
  logic [FPU_CMD_W-1:0]  fpu_cmd;
  logic [FPU_DATA_W-1:0] fpu_din1;
  logic [FPU_DATA_W-1:0] fpu_din2;
  logic                  fpu_done;
  logic [FPU_DATA_W-1:0] fpu_result;

  modport master (
    output fpu_val, fpu_cmd, fpu_din1, fpu_din2,
    input  fpu_done, fpu_result
  );

  modport slave (
    input  fpu_val, fpu_cmd, fpu_din1, fpu_din2,
    output fpu_done, fpu_result
  );

endinterface

// File: rtl/fpu_arb_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req   request vector
//   last  index granted most recently; the search starts just above it
//   gnt   one-hot grant
//   idx   binary index of the grant
//   any   1 when some request is present
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Walk the N positions starting at last+1 (wrapping) and stop at the first hit;
  // last itself is examined last, so a repeat winner only happens when it is alone.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(last) + k) % N]) begin
        any                          = 1'b1;
        idx                          = IW'((int'(last) + k) % N);
        gnt[(int'(last) + k) % N]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_arb.sv
// Round-robin scheduler sharing one FPU between NREQ requesters, with a watchdog.
// Ports:
//   mclk, rst_n     clock, asynchronous active-low reset
//   req_val         per-requester request level, held until req_ack
//   req_cmd         per-requester command, slice i = [4i+3:4i]
//   req_din1/2      per-requester operands, slice i = [32i+31:32i]
//   req_ack         one-cycle accept pulse to the granted requester
//   rsp_val         one-cycle completion pulse to the owner
//   rsp_err         1 = the completion was a timeout (result invalid)
//   rsp_result      result, held until the next completion
//   fpu             master side of the FPU bus
//   idle            1 when nothing is in flight and nobody is requesting
module fpu_arb
  import fpu_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 1023
) (
  input  logic                       mclk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_val,
  input  logic [NREQ*FPU_CMD_W-1:0]  req_cmd,
  input  logic [NREQ*FPU_DATA_W-1:0] req_din1,
  input  logic [NREQ*FPU_DATA_W-1:0] req_din2,
  output logic [NREQ-1:0]            req_ack,
  output logic [NREQ-1:0]            rsp_val,
  output logic                       rsp_err,
  output logic [FPU_DATA_W-1:0]      rsp_result,
  fpu_arb_if.master                  fpu,
  output logic                       idle
);

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  // Count value seen during the last allowed WAIT cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

  fpu_arb_st_e           state_q, state_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [FPU_CMD_W-1:0]  cmd_q, cmd_d;
  logic [FPU_DATA_W-1:0] din1_q, din1_d;
  logic [FPU_DATA_W-1:0] din2_q, din2_d;
  logic [NREQ-1:0]       req_ack_q, req_ack_d;
  logic                  fpu_val_q, fpu_val_d;
  logic [NREQ-1:0]       rsp_val_q, rsp_val_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [FPU_DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NREQ-1:0]       arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  fin;
  logic                  fin_err;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req  (req_val),
    .last (last_grant_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    din1_d       = din1_q;
    din2_d       = din2_q;
    req_ack_d    = '0;
    fpu_val_d    = 1'b0;
    rsp_val_d    = '0;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    cnt_d        = cnt_q;
    fin          = 1'b0;
    fin_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d   = arb_idx;
          cmd_d     = req_cmd[arb_idx*FPU_CMD_W +: FPU_CMD_W];
          din1_d    = req_din1[arb_idx*FPU_DATA_W +: FPU_DATA_W];
          din2_d    = req_din2[arb_idx*FPU_DATA_W +: FPU_DATA_W];
          req_ack_d = arb_gnt;
          fpu_val_d = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // A very fast FPU may answer in the same cycle it is started.
        if (fpu.fpu_done) fin = 1'b1;
        else              state_d = WAIT;
      end
      WAIT: begin
        // Done is tested first so that it beats a coinciding timeout.
        if (fpu.fpu_done) begin
          fin = 1'b1;
        end else if ((TMO_CYC != 0) && (cnt_q == TMO_LAST)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The pointer also advances on a timeout so a stuck requester cannot
    // keep first priority over the others.
    if (fin) begin
      rsp_val_d[owner_q] = 1'b1;
      rsp_err_d          = fin_err;
      rsp_result_d       = fin_err ? '0 : fpu.fpu_result;
      last_grant_d       = owner_q;
      state_d            = IDLE;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      owner_q      <= '0;
      cmd_q        <= '0;
      din1_q       <= '0;
      din2_q       <= '0;
      req_ack_q    <= '0;
      fpu_val_q    <= 1'b0;
      rsp_val_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      din1_q       <= din1_d;
      din2_q       <= din2_d;
      req_ack_q    <= req_ack_d;
      fpu_val_q    <= fpu_val_d;
      rsp_val_q    <= rsp_val_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign rsp_val      = rsp_val_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_result   = rsp_result_q;
  assign fpu.fpu_val  = fpu_val_q;
  assign fpu.fpu_cmd  = cmd_q;
  assign fpu.fpu_din1 = din1_q;
  assign fpu.fpu_din2 = din2_q;
  assign idle         = (state_q == IDLE) && (req_val == '0);

endmodule

// File: tb/tb_fpu_arb.sv
// Self-checking bench for fpu_arb: plays the requesters and the FPU, and predicts
// every response from a transaction-level model (winner search, response time
// from the FPU delay and the watchdog limit).
module tb_fpu_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic                 mclk  = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_val;
  logic [NREQ*4-1:0]    req_cmd;
  logic [NREQ*32-1:0]   req_din1;
  logic [NREQ*32-1:0]   req_din2;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      rsp_val;
  logic                 rsp_err;
  logic [31:0]          rsp_result;
  logic                 idle;

  fpu_arb_if fpu ();

  fpu_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .req_val    (req_val),
    .req_cmd    (req_cmd),
    .req_din1   (req_din1),
    .req_din2   (req_din2),
    .req_ack    (req_ack),
    .rsp_val    (rsp_val),
    .rsp_err    (rsp_err),
    .rsp_result (rsp_result),
    .fpu        (fpu),
    .idle       (idle)
  );

  always #5 mclk = ~mclk;

  int          nChecks = 0;
  int          nPass   = 0;
  int          lastGrant;
  bit          prevErr;
  logic [31:0] prevRes;
  logic [3:0]  lastCmd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic stepCycle();
    @(posedge mclk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [3:0] cmd, input logic [31:0] d1,
                               input logic [31:0] d2);
    req_val[i]          = 1'b1;
    req_cmd[i*4 +: 4]   = cmd;
    req_din1[i*32 +: 32] = d1;
    req_din2[i*32 +: 32] = d2;
  endtask

  // Round-robin reference: first requester after the last winner, wrapping.
  function automatic int pickWinner(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ack"},    32'(req_ack), 0);
    checkOutput({tag, "_rsp_val"},    32'(rsp_val), 0);
    checkOutput({tag, "_rsp_err"},    32'(rsp_err), 0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 0);
    checkOutput({tag, "_fpu_val"},    32'(fpu.fpu_val), 0);
    checkOutput({tag, "_fpu_cmd"},    32'(fpu.fpu_cmd), 0);
    checkOutput({tag, "_fpu_din1"},   fpu.fpu_din1, 0);
    checkOutput({tag, "_fpu_din2"},   fpu.fpu_din2, 0);
    checkOutput({tag, "_idle"},       32'(idle), 1);
  endtask

  task automatic doReset();
    req_val         = '0;
    fpu.fpu_done    = 1'b0;
    rst_n           = 1'b0;
    #2;
    checkResetState("reset");
    repeat (2) stepCycle();
    rst_n     = 1'b1;
    lastGrant = NREQ - 1;
    prevErr   = 1'b0;
    prevRes   = '0;
    lastCmd   = '0;
  endtask

  // Idle cycles with no request pending; optionally pulse fpu_done, which must be ignored.
  task automatic idleGap(input int n, input bit pulseDone);
    for (int j = 0; j < n; j++) begin
      #1;
      checkOutput("idle_gap", 32'(idle), 1);
      if (pulseDone) begin
        fpu.fpu_done   = 1'b1;
        fpu.fpu_result = $urandom;
      end
      stepCycle();
      fpu.fpu_done = 1'b0;
      checkOutput("gap_rsp_val", 32'(rsp_val), 0);
      checkOutput("gap_req_ack", 32'(req_ack), 0);
      checkOutput("gap_fpu_val", 32'(fpu.fpu_val), 0);
      checkOutput("gap_cmd_hold", 32'(fpu.fpu_cmd), 32'(lastCmd));
    end
  endtask

  task automatic churnReqs();
    for (int i = 0; i < NREQ; i++) begin
      if (!req_val[i]) begin
        if ($urandom_range(0, 7) == 0) applyStimulus(i, 4'($urandom), $urandom, $urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req_val[i] = 1'b0;
      end
    end
  endtask

  // One full operation, entered in a cycle where the DUT is idle and req_val is non-zero.
  // dly = FPU answer delay in cycles after the fpu_val cycle (0 = same cycle).
  // churn: 0 none, 1 random request traffic, 2 requester 1 raises then withdraws.
  task automatic serveOne(input int dly, input logic [31:0] res, input bit hold,
                          input int churn, output logic [3:0] ackSeen);
    int          w;
    int          rspOff;
    bit          err;
    logic [3:0]  c;
    logic [31:0] d1, d2, expRes;
    ackSeen = '0;
    w = pickWinner(req_val, lastGrant);
    if (w >= 0) begin
      c  = req_cmd[w*4 +: 4];
      d1 = req_din1[w*32 +: 32];
      d2 = req_din2[w*32 +: 32];
      stepCycle();
      ackSeen = req_ack;
      checkOutput("req_ack", 32'(req_ack), 32'(1) << w);
      checkOutput("fpu_val", 32'(fpu.fpu_val), 1);
      checkOutput("fpu_cmd", 32'(fpu.fpu_cmd), 32'(c));
      checkOutput("fpu_din1", fpu.fpu_din1, d1);
      checkOutput("fpu_din2", fpu.fpu_din2, d2);
      checkOutput("issue_rsp_val", 32'(rsp_val), 0);
      if (!hold) req_val[w] = 1'b0;
      err    = (dly > TMO);
      rspOff = err ? TMO + 1 : dly + 1;
      expRes = err ? 32'h0 : res;
      if (dly == 0) begin
        fpu.fpu_done   = 1'b1;
        fpu.fpu_result = res;
      end
      for (int t = 1; t < rspOff; t++) begin
        stepCycle();
        fpu.fpu_done   = 1'b0;
        fpu.fpu_result = $urandom;
        checkOutput("busy_req_ack", 32'(req_ack), 0);
        checkOutput("busy_fpu_val", 32'(fpu.fpu_val), 0);
        checkOutput("busy_rsp_val", 32'(rsp_val), 0);
        checkOutput("busy_rsp_err", 32'(rsp_err), 32'(prevErr));
        checkOutput("busy_rsp_result", rsp_result, prevRes);
        checkOutput("busy_cmd_hold", 32'(fpu.fpu_cmd), 32'(c));
        checkOutput("busy_din1_hold", fpu.fpu_din1, d1);
        checkOutput("busy_idle", 32'(idle), 0);
        if (t == dly) begin
          fpu.fpu_done   = 1'b1;
          fpu.fpu_result = res;
        end
        if (churn == 1) churnReqs();
        else if (churn == 2 && t == 1) applyStimulus(1, 4'h5, 32'h12345678, 32'h9ABCDEF0);
        else if (churn == 2 && t == 2) req_val[1] = 1'b0;
      end
      stepCycle();
      fpu.fpu_done = 1'b0;
      checkOutput("rsp_val", 32'(rsp_val), 32'(1) << w);
      checkOutput("rsp_err", 32'(rsp_err), 32'(err));
      checkOutput("rsp_result", rsp_result, expRes);
      checkOutput("rsp_req_ack", 32'(req_ack), 0);
      checkOutput("rsp_din2_hold", fpu.fpu_din2, d2);
      lastGrant = w;
      prevErr   = err;
      prevRes   = expRes;
      lastCmd   = c;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ack, prevAck;
    int         order [5];
    order = '{0, 1, 2, 3, 0};
    req_val = '0; req_cmd = '0; req_din1 = '0; req_din2 = '0;
    fpu.fpu_done = 1'b0; fpu.fpu_result = '0;
    #1;
    doReset();

    // Single operation with known operands; FPU answers in cycle 5.
    applyStimulus(2, 4'h3, 32'h3F800000, 32'h40000000);
    serveOne(4, 32'h40400000, 1'b0, 0, ack);
    idleGap(2, 1'b1);

    // Fairness with everyone requesting continuously.
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 4'($urandom), $urandom, $urandom);
    prevAck = '0;
    for (int k = 0; k < 5; k++) begin
      serveOne(3, $urandom, 1'b1, 0, ack);
      checkOutput("rr_order", 32'(ack), 32'(1) << order[k]);
      if (k > 0) checkOutput("no_repeat", 32'(ack == prevAck), 0);
      prevAck = ack;
    end
    req_val = '0;
    idleGap(1, 1'b0);

    // Watchdog expiry, then a normal operation.
    applyStimulus(1, 4'h7, 32'hAAAA5555, 32'h5555AAAA);
    serveOne(20, 32'hFFFFFFFF, 1'b0, 0, ack);
    applyStimulus(2, 4'h9, 32'h01020304, 32'h05060708);
    serveOne(2, 32'hCAFEF00D, 1'b0, 0, ack);
    // Done arriving in the very cycle the watchdog would fire.
    applyStimulus(0, 4'h2, 32'h0000FFFF, 32'hFFFF0000);
    serveOne(TMO, 32'h13579BDF, 1'b0, 0, ack);
    idleGap(1, 1'b0);

    // A requester that raises and withdraws while the FPU is busy is never acked.
    applyStimulus(0, 4'h4, 32'h00000011, 32'h00000022);
    serveOne(5, 32'h00000033, 1'b0, 2, ack);
    idleGap(3, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      if (req_val == '0) begin
        idleGap($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        applyStimulus($urandom_range(0, NREQ - 1), 4'($urandom), $urandom, $urandom);
        for (int i = 0; i < NREQ; i++)
          if (!req_val[i] && $urandom_range(0, 2) == 0)
            applyStimulus(i, 4'($urandom), $urandom, $urandom);
      end
      serveOne($urandom_range(0, TMO + 3), $urandom, 1'b0, 1, ack);
    end
    req_val = '0;

    // Reset while an operation is waiting on the FPU.
    idleGap(1, 1'b0);
    applyStimulus(3, 4'hB, 32'h76543210, 32'hFEDCBA98);
    serveOne(1, 32'hDEADBEEF, 1'b0, 0, ack);
    idleGap(1, 1'b0);
    applyStimulus(0, 4'hA, 32'h11111111, 32'h22222222);
    stepCycle();
    checkOutput("t5_req_ack", 32'(req_ack), 32'h1);
    req_val = '0;
    repeat (2) stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midop_reset");
    repeat (2) stepCycle();
    rst_n     = 1'b1;
    lastGrant = NREQ - 1;
    fpu.fpu_done   = 1'b1;
    fpu.fpu_result = 32'h55555555;
    stepCycle();
    fpu.fpu_done = 1'b0;
    checkOutput("late_done_rsp_val", 32'(rsp_val), 0);
    checkOutput("late_done_idle", 32'(idle), 1);
    stepCycle();
    checkOutput("late_done_rsp_val2", 32'(rsp_val), 0);
    checkOutput("late_done_result", rsp_result, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
